// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte write to rx_data, byte read from tx_data.
// Bus events lag the pins by SYNC_STAGES+1 clks; the bus is never stretched.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       rd_nack
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt, w_shift_in;
  logic [6:0] r_tx_shift, w_tx_shift_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_byte_done, w_byte_done_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_load, w_tx_load_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_rd_nack, w_rd_nack_nxt;

  // Synchronizers reset to 1 so an idle bus produces no edge on reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_d & w_sda;
  assign w_shift_in = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_tx_shift  <= 7'h00;
      r_rw        <= 1'b0;
      r_byte_done <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_nack   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_rw        <= w_rw_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_load   <= w_tx_load_nxt;
      r_busy      <= w_busy_nxt;
      r_rd_nack   <= w_rd_nack_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_tx_shift_nxt  = r_tx_shift;
    w_rw_nxt        = r_rw;
    w_byte_done_nxt = r_byte_done;
    w_sda_oe_nxt    = r_sda_oe;
    w_rx_data_nxt   = r_rx_data;
    w_busy_nxt      = r_busy;
    w_rx_valid_nxt  = 1'b0;
    w_tx_load_nxt   = 1'b0;
    w_rd_nack_nxt   = 1'b0;
    if (w_start) begin
      // sda_oe is left alone here: SCL is high, so any release waits for the next fall.
      w_state_nxt     = ADDR;
      w_bit_cnt_nxt   = 3'd0;
      w_byte_done_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ADDR, WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_shift_in;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_byte_done_nxt = 1'b1;
              if (r_state == WR_BYTE) begin
                w_rx_data_nxt  = w_shift_in;
                w_rx_valid_nxt = 1'b1;
              end
            end
          end else if (w_scl_fall) begin
            if (r_byte_done) begin
              w_byte_done_nxt = 1'b0;
              if (r_state == WR_BYTE) begin
                w_sda_oe_nxt = 1'b1;
                w_state_nxt  = WR_ACK;
              end else if (r_shift[7:1] == TARGET_ADDR) begin
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                w_rw_nxt     = r_shift[0];
                w_state_nxt  = ADDR_ACK;
              end else begin
                w_sda_oe_nxt = 1'b0;
                w_state_nxt  = WAIT_STOP;
              end
            end else begin
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt = 3'd0;
            if (r_rw) begin
              w_tx_load_nxt  = 1'b1;
              w_tx_shift_nxt = tx_data[6:0];
              w_sda_oe_nxt   = ~tx_data[7];
              w_state_nxt    = RD_BYTE;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = WR_BYTE;
            end
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = RD_ACK;
            end else begin
              w_sda_oe_nxt   = ~r_tx_shift[6];
              w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_rd_nack_nxt = 1'b1;
              w_state_nxt   = WAIT_STOP;
            end else begin
              w_byte_done_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_byte_done) begin
            w_byte_done_nxt = 1'b0;
            w_tx_load_nxt   = 1'b1;
            w_tx_shift_nxt  = tx_data[6:0];
            w_sda_oe_nxt    = ~tx_data[7];
            w_bit_cnt_nxt   = 3'd0;
            w_state_nxt     = RD_BYTE;
          end
        end
        WAIT_STOP: w_sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_load  = r_tx_load;
  assign busy     = r_busy;
  assign rd_nack  = r_rd_nack;

endmodule
